// File: rtl/path_trace_frame_scheduler_if.sv
// Pixel-pipe control and framebuffer-write bundle for path_trace_frame_scheduler.
// master = scheduler side, slave = pixel pipe / framebuffer side.
interface path_trace_frame_scheduler_if #(
  parameter int PX_WIDTH      = 9,
  parameter int PY_WIDTH      = 8,
  parameter int BOUNCES_WIDTH = 4,
  parameter int RPP_WIDTH     = 4
);
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vec3_t;

  logic                     pix_start;
  logic [PX_WIDTH-1:0]      pix_x;
  logic [PY_WIDTH-1:0]      pix_y;
  logic [BOUNCES_WIDTH-1:0] pix_max_bounces;
  logic                     pix_busy;
  logic                     pix_ray_color_wr_en;
  logic [RPP_WIDTH-1:0]     pix_ray_color_update_ndx;
  vec3_t                    pix_ray_color;

  logic                     fb_wr_en;
  logic [PX_WIDTH-1:0]      fb_x;
  logic [PY_WIDTH-1:0]      fb_y;
  logic [RPP_WIDTH-1:0]     fb_ray_ndx;
  vec3_t                    fb_color;

  modport master (
    output pix_start, pix_x, pix_y, pix_max_bounces,
    input  pix_busy, pix_ray_color_wr_en, pix_ray_color_update_ndx, pix_ray_color,
    output fb_wr_en, fb_x, fb_y, fb_ray_ndx, fb_color
  );

  modport slave (
    input  pix_start, pix_x, pix_y, pix_max_bounces,
    output pix_busy, pix_ray_color_wr_en, pix_ray_color_update_ndx, pix_ray_color,
    input  fb_wr_en, fb_x, fb_y, fb_ray_ndx, fb_color
  );
endinterface

// File: rtl/path_trace_frame_scheduler.sv
// Raster-order frame sequencer: launches one pixel at a time into path_trace_pixel and forwards its writes.
// Optional macro FRAME_SCHED_PERF_EN adds the frame_cycles / pixel_cycles_max counters.
module path_trace_frame_scheduler #(
  parameter int FRAME_WIDTH   = 320,
  parameter int FRAME_HEIGHT  = 240,
  parameter int PX_WIDTH      = 9,
  parameter int PY_WIDTH      = 8,
  parameter int BOUNCES_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [BOUNCES_WIDTH-1:0] max_bounces,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     aborted,
`ifdef FRAME_SCHED_PERF_EN
  output logic [31:0]              frame_cycles,
  output logic [31:0]              pixel_cycles_max,
`endif
  path_trace_frame_scheduler_if.master bus
);
  localparam logic [PX_WIDTH-1:0]      X_LAST = PX_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [PY_WIDTH-1:0]      Y_LAST = PY_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [PX_WIDTH-1:0]      X_ZERO = {PX_WIDTH{1'b0}};
  localparam logic [PY_WIDTH-1:0]      Y_ZERO = {PY_WIDTH{1'b0}};
  localparam logic [BOUNCES_WIDTH-1:0] B_ZERO = {BOUNCES_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_RUN     = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  state_t state_r;
  logic   last_px_s;

  assign last_px_s = (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);

  // Decided inside the ADVANCE cycle itself so busy drops the cycle after the pulse.
  assign frame_done = !rst && (state_r == ST_ADVANCE) && (abort || last_px_s);

  // Frame sequencing FSM with registered control outputs and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      busy                <= 1'b0;
      aborted             <= 1'b0;
      bus.pix_start       <= 1'b0;
      bus.pix_x           <= X_ZERO;
      bus.pix_y           <= Y_ZERO;
      bus.pix_max_bounces <= B_ZERO;
    end else begin
      bus.pix_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r             <= ST_ISSUE;
            busy                <= 1'b1;
            aborted             <= 1'b0;
            bus.pix_start       <= 1'b1;
            bus.pix_x           <= X_ZERO;
            bus.pix_y           <= Y_ZERO;
            bus.pix_max_bounces <= max_bounces;
          end
        end
        ST_ISSUE:  state_r <= ST_LAUNCH;
        // The pipe's busy is registered, so it is only trustworthy from RUN onward.
        ST_LAUNCH: state_r <= ST_RUN;
        ST_RUN: begin
          if (!bus.pix_busy) begin
            state_r <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (last_px_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r       <= ST_ISSUE;
            bus.pix_start <= 1'b1;
            if (bus.pix_x == X_LAST) begin
              bus.pix_x <= X_ZERO;
              bus.pix_y <= bus.pix_y + PY_WIDTH'(1'b1);
            end else begin
              bus.pix_x <= bus.pix_x + PX_WIDTH'(1'b1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Framebuffer write forwarding, tagged with the coordinates of the pixel in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fb_wr_en   <= 1'b0;
      bus.fb_x       <= X_ZERO;
      bus.fb_y       <= Y_ZERO;
      bus.fb_ray_ndx <= '0;
      bus.fb_color   <= '0;
    end else begin
      bus.fb_wr_en <= bus.pix_ray_color_wr_en;
      if (bus.pix_ray_color_wr_en) begin
        bus.fb_x       <= bus.pix_x;
        bus.fb_y       <= bus.pix_y;
        bus.fb_ray_ndx <= bus.pix_ray_color_update_ndx;
        bus.fb_color   <= bus.pix_ray_color;
      end
    end
  end

`ifdef FRAME_SCHED_PERF_EN
  logic [31:0] pix_cycles_r;

  // Frame busy-cycle counter (saturating) and worst ISSUE..ADVANCE pixel latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cycles     <= 32'd0;
      pixel_cycles_max <= 32'd0;
      pix_cycles_r     <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      frame_cycles     <= 32'd0;
      pixel_cycles_max <= 32'd0;
      pix_cycles_r     <= 32'd1;
    end else begin
      if (busy && (frame_cycles != 32'hFFFF_FFFF)) begin
        frame_cycles <= frame_cycles + 32'd1;
      end
      if (state_r == ST_ADVANCE) begin
        if (pix_cycles_r > pixel_cycles_max) begin
          pixel_cycles_max <= pix_cycles_r;
        end
        pix_cycles_r <= 32'd1;
      end else if (busy && (pix_cycles_r != 32'hFFFF_FFFF)) begin
        pix_cycles_r <= pix_cycles_r + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_path_trace_frame_scheduler.sv
// Randomized self-checking bench for path_trace_frame_scheduler on a 4x2 frame with a behavioural pixel pipe.
module tb_path_trace_frame_scheduler;
  localparam int FW   = 4;
  localparam int FH   = 2;
  localparam int NPIX = FW * FH;
  localparam int PXW  = 9;
  localparam int PYW  = 8;
  localparam int BW   = 4;
  localparam int RW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] max_bounces = '0;
  logic          busy;
  logic          frame_done;
  logic          aborted;
`ifdef FRAME_SCHED_PERF_EN
  logic [31:0]   frame_cycles;
  logic [31:0]   pixel_cycles_max;
`endif

  path_trace_frame_scheduler_if #(.PX_WIDTH(PXW), .PY_WIDTH(PYW), .BOUNCES_WIDTH(BW), .RPP_WIDTH(RW)) bus ();

  path_trace_frame_scheduler #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PX_WIDTH(PXW), .PY_WIDTH(PYW), .BOUNCES_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .max_bounces(max_bounces),
    .busy(busy),
    .frame_done(frame_done),
    .aborted(aborted),
`ifdef FRAME_SCHED_PERF_EN
    .frame_cycles(frame_cycles),
    .pixel_cycles_max(pixel_cycles_max),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fixed_n = 0;
  // Reference model: frame activity, current pixel index, its issue cycle and pipe latency.
  bit            m_active = 1'b0;
  bit            m_aborted = 1'b0;
  int            m_issue = 0;
  int            m_n = 4;
  int            m_k = 0;
  logic [BW-1:0] m_mb = '0;
  int            p_cnt = 0;
  int            p_wr_left = 0;
  bit            exp_wr = 1'b0;
  int            exp_x = 0;
  int            exp_y = 0;
  int            exp_ndx = 0;
  logic [47:0]   exp_col = '0;
  bit            chk_reset = 1'b0;
  int            n_issue = 0;
  int            n_wr = 0;
`ifdef FRAME_SCHED_PERF_EN
  bit            perf_chk = 1'b0;
  int            m_busy_cnt = 0;
  int            m_nmax = 0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pick_n();
    if (fixed_n != 0) return fixed_n;
    return int'($urandom_range(4, 12));
  endfunction

  // One clock: check outputs of this cycle, run the pixel pipe, apply inputs, advance the model.
  task automatic step(input logic st, input logic ab, input logic rs, input logic [BW-1:0] mb);
    int          adv;
    bit          in_adv;
    bit          last;
    logic [63:0] r64;
    logic [47:0] col;
    @(negedge clk);
    adv    = m_issue + m_n + 2;
    in_adv = m_active && (cyc == adv);
    last   = (m_k == NPIX - 1);
    check_eq("busy", 64'(busy), 64'(m_active));
    check_eq("pix_start", 64'(bus.pix_start), 64'(m_active && (cyc == m_issue)));
    check_eq("frame_done", 64'(frame_done), 64'(in_adv && (abort || last)));
    check_eq("aborted", 64'(aborted), 64'(m_aborted));
    check_eq("fb_wr_en", 64'(bus.fb_wr_en), 64'(exp_wr));
    if (exp_wr && bus.fb_wr_en) begin
      col = bus.fb_color;
      check_eq("fb_x", 64'(bus.fb_x), 64'(exp_x));
      check_eq("fb_y", 64'(bus.fb_y), 64'(exp_y));
      check_eq("fb_ray_ndx", 64'(bus.fb_ray_ndx), 64'(exp_ndx));
      check_eq("fb_color", 64'(col), 64'(exp_col));
    end
    if (m_active && (cyc >= m_issue) && (cyc < adv)) begin
      check_eq("pix_x", 64'(bus.pix_x), 64'(m_k % FW));
      check_eq("pix_y", 64'(bus.pix_y), 64'(m_k / FW));
      check_eq("pix_max_bounces", 64'(bus.pix_max_bounces), 64'(m_mb));
    end
    if (chk_reset) begin
      col = bus.fb_color;
      check_eq("rst_pix_x", 64'(bus.pix_x), 64'd0);
      check_eq("rst_pix_y", 64'(bus.pix_y), 64'd0);
      check_eq("rst_pix_mb", 64'(bus.pix_max_bounces), 64'd0);
      check_eq("rst_fb_x", 64'(bus.fb_x), 64'd0);
      check_eq("rst_fb_y", 64'(bus.fb_y), 64'd0);
      check_eq("rst_fb_ndx", 64'(bus.fb_ray_ndx), 64'd0);
      check_eq("rst_fb_color", 64'(col), 64'd0);
      chk_reset = 1'b0;
    end
`ifdef FRAME_SCHED_PERF_EN
    if (perf_chk) begin
      check_eq("frame_cycles", 64'(frame_cycles), 64'(m_busy_cnt));
      check_eq("pixel_cycles_max", 64'(pixel_cycles_max), 64'(m_nmax + 3));
      perf_chk = 1'b0;
    end
`endif
    if (bus.pix_start) n_issue++;
    if (bus.fb_wr_en) n_wr++;

    // Pixel pipe: busy for m_n cycles after pix_start, four writes (ndx 0..3) spread over them.
    bus.pix_ray_color_wr_en = 1'b0;
    exp_wr = 1'b0;
    if (p_cnt > 0) begin
      bus.pix_busy = 1'b1;
      if (p_wr_left > 0 && (p_wr_left >= p_cnt || $urandom_range(0, 1) == 1)) begin
        r64 = {$urandom(), $urandom()};
        bus.pix_ray_color_wr_en      = 1'b1;
        bus.pix_ray_color_update_ndx = RW'(4 - p_wr_left);
        bus.pix_ray_color            = r64[47:0];
        exp_wr  = 1'b1;
        exp_x   = m_k % FW;
        exp_y   = m_k / FW;
        exp_ndx = 4 - p_wr_left;
        exp_col = r64[47:0];
        p_wr_left--;
      end
      p_cnt--;
    end else begin
      bus.pix_busy = 1'b0;
    end
    if (bus.pix_start) begin
      p_cnt     = m_n;
      p_wr_left = 4;
    end

    start       = st;
    abort       = ab;
    rst         = rs;
    max_bounces = mb;
    if (rs) begin
      bus.pix_busy            = 1'b0;
      bus.pix_ray_color_wr_en = 1'b0;
      p_cnt     = 0;
      p_wr_left = 0;
      exp_wr    = 1'b0;
    end

`ifdef FRAME_SCHED_PERF_EN
    if (m_active) m_busy_cnt++;
`endif
    if (rs) begin
      m_active  = 1'b0;
      m_aborted = 1'b0;
      chk_reset = 1'b1;
    end else if (in_adv) begin
      if (ab || last) begin
        m_active  = 1'b0;
        m_aborted = ab;
`ifdef FRAME_SCHED_PERF_EN
        perf_chk = 1'b1;
`endif
      end else begin
        m_k++;
        m_issue = cyc + 1;
        m_n     = pick_n();
`ifdef FRAME_SCHED_PERF_EN
        if (m_n > m_nmax) m_nmax = m_n;
`endif
      end
    end else if (!m_active && st) begin
      m_active  = 1'b1;
      m_aborted = 1'b0;
      m_k       = 0;
      m_issue   = cyc + 1;
      m_n       = pick_n();
      m_mb      = mb;
`ifdef FRAME_SCHED_PERF_EN
      m_busy_cnt = 0;
      m_nmax     = m_n;
`endif
    end
    cyc++;
  endtask

  // Full frame; spur injects ignored starts (incl. the frame_done cycle); abort_k >= 0 aborts at that pixel.
  task automatic run_frame(input bit spur, input int abort_k, input logic [BW-1:0] mb);
    int budget;
    bit st;
    bit ab;
    int exp_issues;
    n_issue = 0;
    n_wr    = 0;
    ab      = 1'b0;
    budget  = 0;
    step(1'b1, 1'b0, 1'b0, mb);
    while (m_active && budget < 600) begin
      st = spur && (($urandom_range(0, 7) == 0) ||
                    ((m_k == NPIX - 1) && (cyc == m_issue + m_n + 2)));
      if (abort_k >= 0 && m_k == abort_k && cyc == m_issue + 2) ab = 1'b1;
      step(st, ab, 1'b0, BW'($urandom()));
      budget++;
    end
    if (budget >= 600) check_eq("frame_timeout", 64'd1, 64'd0);
    step(1'b0, 1'b0, 1'b0, mb);
    step(1'b0, 1'b0, 1'b0, mb);
    exp_issues = (abort_k >= 0) ? abort_k + 1 : NPIX;
    check_eq("issues", 64'(n_issue), 64'(exp_issues));
    check_eq("writes", 64'(n_wr), 64'(4 * exp_issues));
  endtask

  initial begin
    int budget;
    int ak;
    bit rs;
    bus.pix_busy                 = 1'b0;
    bus.pix_ray_color_wr_en      = 1'b0;
    bus.pix_ray_color_update_ndx = '0;
    bus.pix_ray_color            = '0;
    repeat (3) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    fixed_n = 10;
    run_frame(1'b0, -1, BW'(5));
    run_frame(1'b1, -1, BW'(9));
    run_frame(1'b0, 1, BW'(2));
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);

    // Reset during RUN of pixel (2,1), then a fresh frame with bounce limit 3.
    step(1'b1, 1'b0, 1'b0, BW'(7));
    budget = 0;
    while (m_active && budget < 600) begin
      rs = (m_k == 6) && (cyc == m_issue + 3);
      step(1'b0, 1'b0, rs, '0);
      budget++;
      if (rs) break;
    end
    if (budget >= 600) check_eq("reset_timeout", 64'd1, 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    run_frame(1'b0, -1, BW'(3));

    fixed_n = 0;
    for (int f = 0; f < 6; f++) begin
      ak = int'($urandom_range(0, 11));
      run_frame(1'($urandom_range(0, 1)), (ak < NPIX) ? ak : -1, BW'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
